// File: rtl/fft_out_serializer.sv
// Ping-pong output buffer for the FFT core: reorders bins to natural order and
// streams them one per clock, applying 1/N rounding on inverse-transform frames.
module fft_out_serializer #(
   parameter int N      = 256,
   parameter int LOGN   = 8,
   parameter int DW     = 16,
   parameter bit BITREV = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en,
   input  logic [LOGN-1:0] wr_addr,
   input  logic [DW-1:0]   wr_re,
   input  logic [DW-1:0]   wr_im,
   input  logic            frame_done,
   input  logic            inv_in,
   output logic            valid_out,
   output logic            sop_out,
   output logic            eop_out,
   output logic [DW-1:0]   y_re,
   output logic [DW-1:0]   y_im,
   output logic            busy,
   output logic            overflow
);

   typedef enum logic {IDLE, READ} state_t;

   localparam logic [LOGN-1:0] ADDR_LAST   = LOGN'(N - 1);
   localparam logic [LOGN-1:0] ADDR_PENULT = LOGN'(N - 2);
   localparam logic signed [DW:0] RND      = (DW+1)'(1) << (LOGN - 1);

   function automatic logic [LOGN-1:0] bit_rev(input logic [LOGN-1:0] a);
      logic [LOGN-1:0] r;
      r = '0;
      for (int i = 0; i < LOGN; i++) r[i] = a[LOGN-1-i];
      return r;
   endfunction

   // Round-half-up divide by N; the extra bit keeps d + N/2 from wrapping.
   function automatic logic signed [DW-1:0] scale_inv(input logic signed [DW-1:0] d);
      logic signed [DW:0] sum;
      logic signed [DW:0] shf;
      sum = {d[DW-1], d} + RND;
      shf = sum >>> LOGN;
      return shf[DW-1:0];
   endfunction

   logic [2*DW-1:0]    mem [2*N];
   logic [1:0]         full_q;
   logic [1:0]         inv_q;
   logic               wr_bank_q;
   logic               rd_bank_q;
   state_t             state_q;
   state_t             state_d;
   logic [LOGN-1:0]    rd_addr_p0;
   logic [LOGN-1:0]    rd_addr_d;
   logic               cur_bank_p0;
   logic               cur_inv_p0;
   logic               start_frame;
   logic               release_bank;
   logic [LOGN-1:0]    wr_addr_eff;
   logic               wr_ok;
   logic               fd_ok;
   logic [2*DW-1:0]    rd_data_p1;
   logic signed [DW-1:0] re_p1;
   logic signed [DW-1:0] im_p1;
   logic               vld_p1;
   logic               sop_p1;
   logic               eop_p1;
   logic               inv_p1;

   assign wr_addr_eff = BITREV ? bit_rev(wr_addr) : wr_addr;
   assign wr_ok       = wr_en & ~full_q[wr_bank_q];
   assign fd_ok       = frame_done & ~full_q[wr_bank_q];
   assign busy        = full_q[0] | full_q[1] | (state_q == READ);

   always_ff @(posedge clk) begin
      if (wr_ok) mem[{wr_bank_q, wr_addr_eff}] <= {wr_re, wr_im};
      rd_data_p1 <= mem[{cur_bank_p0, rd_addr_p0}];
   end

   // The bank is released one address early so the next frame can follow gaplessly.
   always_comb begin
      state_d      = state_q;
      rd_addr_d    = rd_addr_p0;
      start_frame  = 1'b0;
      release_bank = 1'b0;
      case (state_q)
         IDLE: begin
            if (full_q[rd_bank_q]) begin
               state_d     = READ;
               rd_addr_d   = '0;
               start_frame = 1'b1;
            end
         end
         READ: begin
            if (rd_addr_p0 == ADDR_LAST) begin
               if (full_q[rd_bank_q]) begin
                  rd_addr_d   = '0;
                  start_frame = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               rd_addr_d    = rd_addr_p0 + 1'b1;
               release_bank = (rd_addr_p0 == ADDR_PENULT);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Stage p0: bank flags, pointers and read address
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rd_addr_p0  <= '0;
         full_q      <= '0;
         inv_q       <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         cur_bank_p0 <= 1'b0;
         cur_inv_p0  <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_addr_p0 <= rd_addr_d;
         if (start_frame) begin
            cur_bank_p0 <= rd_bank_q;
            cur_inv_p0  <= inv_q[rd_bank_q];
         end
         if (release_bank) begin
            full_q[rd_bank_q] <= 1'b0;
            rd_bank_q         <= ~rd_bank_q;
         end
         if (fd_ok) begin
            full_q[wr_bank_q] <= 1'b1;
            inv_q[wr_bank_q]  <= inv_in;
            wr_bank_q         <= ~wr_bank_q;
         end else if (frame_done) begin
            overflow <= 1'b1;
         end
      end
   end

   // Stage p1: RAM output registered, markers travel alongside
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         sop_p1 <= 1'b0;
         eop_p1 <= 1'b0;
         inv_p1 <= 1'b0;
      end else begin
         vld_p1 <= (state_q == READ);
         sop_p1 <= (state_q == READ) && (rd_addr_p0 == '0);
         eop_p1 <= (state_q == READ) && (rd_addr_p0 == ADDR_LAST);
         inv_p1 <= cur_inv_p0;
      end
   end

   assign re_p1 = rd_data_p1[2*DW-1:DW];
   assign im_p1 = rd_data_p1[DW-1:0];

   // Stage p2: scaling and output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_out <= 1'b0;
         sop_out   <= 1'b0;
         eop_out   <= 1'b0;
         y_re      <= '0;
         y_im      <= '0;
      end else begin
         valid_out <= vld_p1;
         sop_out   <= sop_p1;
         eop_out   <= eop_p1;
         if (vld_p1) begin
            y_re <= inv_p1 ? scale_inv(re_p1) : re_p1;
            y_im <= inv_p1 ? scale_inv(im_p1) : im_p1;
         end
      end
   end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench for fft_out_serializer: two instances (natural and bit-reversed
// write addressing) share one stimulus; expected streams are built per test.
module tb_fft_out_serializer;
   localparam int N = 256;

   logic clk = 1'b0;
   logic rst;
   logic wr_en, frame_done, inv_in;
   logic [7:0] wr_addr;
   logic signed [15:0] wr_re, wr_im;

   logic valid0, sop0, eop0, busy0, ovf0;
   logic signed [15:0] y_re0, y_im0;
   logic valid1, sop1, eop1, busy1, ovf1;
   logic signed [15:0] y_re1, y_im1;

   int total = 0;
   int bad = 0;

   logic signed [15:0] fr_re [256];
   logic signed [15:0] fr_im [256];
   int exp_re [512];
   int exp_im [512];
   int exp1_re [256];
   int exp1_im [256];
   int exp_n = 0;
   int sidx = 0;
   bit armed = 1'b0;
   bit use_br = 1'b0;

   always #5 clk = ~clk;

   fft_out_serializer #(.N(256), .LOGN(8), .DW(16), .BITREV(1'b0)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_re(wr_re), .wr_im(wr_im), .frame_done(frame_done), .inv_in(inv_in),
      .valid_out(valid0), .sop_out(sop0), .eop_out(eop0),
      .y_re(y_re0), .y_im(y_im0), .busy(busy0), .overflow(ovf0)
   );

   fft_out_serializer #(.N(256), .LOGN(8), .DW(16), .BITREV(1'b1)) dut_br (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_re(wr_re), .wr_im(wr_im), .frame_done(frame_done), .inv_in(inv_in),
      .valid_out(valid1), .sop_out(sop1), .eop_out(eop1),
      .y_re(y_re1), .y_im(y_im1), .busy(busy1), .overflow(ovf1)
   );

   function automatic int rev8(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 8; i++) if (v[i]) r = r | (1 << (7 - i));
      return r;
   endfunction

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
      end
   endtask

   // One clock; when armed, compare the output against the expected stream.
   task automatic tick_s();
      @(posedge clk);
      #1;
      if (armed) begin
         sidx++;
         if (sidx < 0 || sidx >= exp_n) begin
            chk("valid_idle", valid0, 0);
            if (sidx >= exp_n) armed = 1'b0;
         end else begin
            chk("valid", valid0, 1);
            chk("sop", sop0, (sidx % N) == 0);
            chk("eop", eop0, (sidx % N) == N - 1);
            chk("y_re", y_re0, exp_re[sidx]);
            chk("y_im", y_im0, exp_im[sidx]);
            if (sidx == exp_n - 3) chk("busy_hold", busy0, 1);
            if (sidx == exp_n - 2) chk("busy_fall", busy0, 0);
            if (use_br) begin
               chk("br_valid", valid1, 1);
               chk("br_sop", sop1, sidx == 0);
               chk("br_eop", eop1, sidx == N - 1);
               chk("br_re", y_re1, exp1_re[sidx]);
               chk("br_im", y_im1, exp1_im[sidx]);
            end
         end
      end
   endtask

   // Writes fr_re/fr_im to bins 0..255 with frame_done on the last write.
   task automatic write_frame(input bit inv, input bit arm);
      for (int k = 0; k < N; k++) begin
         wr_en   = 1'b1;
         wr_addr = 8'(k);
         wr_re   = fr_re[k];
         wr_im   = fr_im[k];
         if (k == N - 1) begin
            frame_done = 1'b1;
            inv_in     = inv;
            if (arm) begin
               armed = 1'b1;
               sidx  = -4;
            end
         end
         tick_s();
      end
      wr_en      = 1'b0;
      frame_done = 1'b0;
      inv_in     = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 700 && armed; t++) tick_s();
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; frame_done = 1'b0; inv_in = 1'b0;
      wr_addr = '0; wr_re = '0; wr_im = '0;
      tick_s();
      tick_s();
      chk("rst_valid", valid0, 0);
      chk("rst_sop", sop0, 0);
      chk("rst_eop", eop0, 0);
      chk("rst_y_re", y_re0, 0);
      chk("rst_y_im", y_im0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_ovf", ovf0, 0);
      chk("rst_br_busy", busy1, 0);
      chk("rst_br_ovf", ovf1, 0);
      rst = 1'b0;
      tick_s();

      // Natural-order frame; the bit-reversed instance sees the same writes
      for (int k = 0; k < N; k++) begin
         fr_re[k] = 16'(k);
         fr_im[k] = 16'(-k);
         exp_re[k] = k;
         exp_im[k] = -k;
         exp1_re[k] = rev8(k);
         exp1_im[k] = -rev8(k);
      end
      exp1_re[1] = 128; exp1_re[2] = 64; exp1_re[3] = 192; exp1_re[255] = 255;
      exp_n = N; use_br = 1'b1;
      write_frame(1'b0, 1'b1);
      chk("busy_after_done", busy0, 1);
      drain();
      use_br = 1'b0;

      // Inverse frame with rounding corner values
      for (int k = 0; k < N; k++) begin
         fr_re[k] = -16'sd300; fr_im[k] = 16'sd300;
         exp_re[k] = -1; exp_im[k] = 1;
      end
      fr_re[0] = 16'sd32767;  fr_re[1] = -16'sd32768; fr_re[2] = 16'sd127;
      fr_re[3] = 16'sd128;    fr_re[4] = -16'sd129;   fr_re[5] = 16'sd0;
      fr_im[0] = 16'sd0;      fr_im[1] = -16'sd129;   fr_im[2] = 16'sd128;
      fr_im[3] = 16'sd127;    fr_im[4] = -16'sd32768; fr_im[5] = 16'sd32767;
      exp_re[0] = 128; exp_re[1] = -128; exp_re[2] = 0;
      exp_re[3] = 1;   exp_re[4] = -1;   exp_re[5] = 0;
      exp_im[0] = 0;   exp_im[1] = -1;   exp_im[2] = 1;
      exp_im[3] = 0;   exp_im[4] = -128; exp_im[5] = 128;
      exp_n = N;
      write_frame(1'b1, 1'b1);
      drain();

      // Back-to-back: A plain, B inverse, B completes as A releases its bank
      for (int k = 0; k < N; k++) begin
         fr_re[k] = 16'(100 * k);
         fr_im[k] = 16'(-100 * k);
         exp_re[k] = 100 * k;
         exp_im[k] = -100 * k;
         exp_re[N + k] = (k + 1) >> 1;
         exp_im[N + k] = -(k >> 1);
      end
      exp_n = 2 * N;
      write_frame(1'b0, 1'b1);
      for (int k = 0; k < N; k++) begin
         fr_re[k] = 16'(128 * k);
         fr_im[k] = 16'(-128 * k);
      end
      write_frame(1'b1, 1'b0);
      drain();

      // Overflow: C fills bank 0, D re-marks bank 1 (still holding B), E dropped
      for (int k = 0; k < N; k++) begin
         fr_re[k] = 16'(7 * k);
         fr_im[k] = 16'(3 * k - 400);
         exp_re[k] = 7 * k;
         exp_im[k] = 3 * k - 400;
      end
      exp_n = 2 * N;
      write_frame(1'b0, 1'b1);
      frame_done = 1'b1; inv_in = 1'b1;
      tick_s();
      frame_done = 1'b0; inv_in = 1'b0;
      chk("ovf_before", ovf0, 0);
      for (int j = 0; j < 99; j++) begin
         wr_en = 1'b1; wr_addr = 8'(255 - j);
         wr_re = 16'sh7777; wr_im = -16'sh1111;
         tick_s();
      end
      wr_en = 1'b0;
      frame_done = 1'b1;
      tick_s();
      frame_done = 1'b0;
      chk("ovf_set", ovf0, 1);
      drain();
      repeat (4) tick_s();
      chk("no_third_frame", valid0, 0);
      chk("ovf_sticky", ovf0, 1);

      // Reset in the middle of frame F
      for (int k = 0; k < N; k++) begin
         fr_re[k] = 16'(k + 1000);
         fr_im[k] = 16'(k - 1000);
         exp_re[k] = k + 1000;
         exp_im[k] = k - 1000;
      end
      exp_n = N;
      write_frame(1'b0, 1'b1);
      for (int t = 0; t < 300 && sidx < 100; t++) tick_s();
      rst = 1'b1;
      #1;
      armed = 1'b0;
      chk("midrst_valid", valid0, 0);
      chk("midrst_sop", sop0, 0);
      chk("midrst_y_re", y_re0, 0);
      chk("midrst_busy", busy0, 0);
      chk("midrst_ovf", ovf0, 0);
      tick_s();
      tick_s();
      rst = 1'b0;
      tick_s();

      // Fresh frame G after reset
      for (int k = 0; k < N; k++) begin
         fr_re[k] = 16'(-5 * k);
         fr_im[k] = 16'(7 * k);
         exp_re[k] = -5 * k;
         exp_im[k] = 7 * k;
      end
      exp_n = N;
      write_frame(1'b0, 1'b1);
      drain();
      chk("final_busy", busy0, 0);
      chk("final_ovf", ovf0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
